// File: rtl/work_mng_types_pkg.sv
// Shared types and default thresholds for the thermal-aware job scheduler.
package work_mng_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        COOL = 2'd2
    } core_state_t;

    localparam int unsigned DEF_NUM_CORES = 3;
    localparam int unsigned DEF_TEMP_W    = 7;
    localparam int unsigned DEF_JOB_W     = 16;
    localparam int unsigned DEF_TAG_W     = 4;
    localparam int unsigned DEF_T_WARN    = 70;
    localparam int unsigned DEF_T_CRIT    = 76;
    localparam int unsigned DEF_T_RESUME  = 60;

endpackage

// File: rtl/core_job_slot.sv
// One core's job tracker: IDLE/RUN/COOL state, remaining-cycle counter and tag.
module core_job_slot
    import work_mng_types_pkg::*;
#(
    parameter int unsigned TEMP_W   = DEF_TEMP_W,
    parameter int unsigned JOB_W    = DEF_JOB_W,
    parameter int unsigned TAG_W    = DEF_TAG_W,
    parameter int unsigned T_CRIT   = DEF_T_CRIT,
    parameter int unsigned T_RESUME = DEF_T_RESUME
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [JOB_W-1:0]  cycles_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [TEMP_W-1:0] temp_i,
    output core_state_t       state_o,
    output logic              busy_o,
    output logic              throttled_o,
    output logic              done_o,
    output logic [TAG_W-1:0]  done_tag_o
);

    localparam logic [TEMP_W-1:0] CritTemp   = TEMP_W'(T_CRIT);
    localparam logic [TEMP_W-1:0] ResumeTemp = TEMP_W'(T_RESUME);

    core_state_t      state_q, state_d;
    logic [JOB_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             done_q, done_d;
    logic [TAG_W-1:0] done_tag_q, done_tag_d;

    // A nonzero counter in COOL means a paused job is still held.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tag_d      = tag_q;
        done_d     = 1'b0;
        done_tag_d = done_tag_q;
        unique case (state_q)
            IDLE: begin
                if (temp_i >= CritTemp) begin
                    state_d = COOL;
                end else if (start_i) begin
                    state_d = RUN;
                    cnt_d   = (cycles_i == '0) ? JOB_W'(1) : cycles_i;
                    tag_d   = tag_i;
                end
            end
            RUN: begin
                if (temp_i >= CritTemp) begin
                    state_d = COOL;
                end else if (cnt_q == JOB_W'(1)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    done_d     = 1'b1;
                    done_tag_d = tag_q;
                end else begin
                    cnt_d = cnt_q - JOB_W'(1);
                end
            end
            COOL: begin
                if (temp_i <= ResumeTemp) begin
                    state_d = (cnt_q != '0) ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tag_q      <= '0;
            done_q     <= 1'b0;
            done_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            done_q     <= done_d;
            done_tag_q <= done_tag_d;
        end
    end

    assign state_o     = state_q;
    assign busy_o      = (state_q == RUN) || ((state_q == COOL) && (cnt_q != '0));
    assign throttled_o = (state_q == COOL);
    assign done_o      = done_q;
    assign done_tag_o  = done_tag_q;

endmodule

// File: rtl/thermal_job_scheduler.sv
// Dispatches jobs to the coolest eligible core and tracks per-core run/throttle state.
module thermal_job_scheduler
    import work_mng_types_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEF_NUM_CORES,
    parameter int unsigned TEMP_W    = DEF_TEMP_W,
    parameter int unsigned JOB_W     = DEF_JOB_W,
    parameter int unsigned TAG_W     = DEF_TAG_W,
    parameter int unsigned T_WARN    = DEF_T_WARN,
    parameter int unsigned T_CRIT    = DEF_T_CRIT,
    parameter int unsigned T_RESUME  = DEF_T_RESUME
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [JOB_W-1:0]            job_cycles,
    input  logic [TAG_W-1:0]            job_tag,
    input  logic [NUM_CORES*TEMP_W-1:0] core_temp,
    output logic [NUM_CORES-1:0]        core_start,
    output logic [TAG_W-1:0]            core_tag,
    output logic [NUM_CORES-1:0]        core_busy,
    output logic [NUM_CORES-1:0]        core_throttled,
    output logic [NUM_CORES-1:0]        done_valid,
    output logic [NUM_CORES*TAG_W-1:0]  done_tag,
    output logic                        all_hot
);

    localparam logic [TEMP_W-1:0] WarnTemp = TEMP_W'(T_WARN);

    logic [NUM_CORES-1:0][TEMP_W-1:0] temp_q, temp_d;
    logic [NUM_CORES-1:0]             core_start_q, core_start_d;
    logic [TAG_W-1:0]                 core_tag_q, core_tag_d;
    core_state_t                      slot_state [NUM_CORES];
    logic [NUM_CORES-1:0]             eligible, sel_oh;
    logic [TEMP_W-1:0]                sel_temp;
    logic                             sel_found, accept, all_hot_c;

    assign temp_d = core_temp;

    // Strict '<' keeps the lowest index on temperature ties.
    always_comb begin
        eligible  = '0;
        sel_oh    = '0;
        sel_temp  = '1;
        sel_found = 1'b0;
        all_hot_c = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            eligible[i] = (slot_state[i] == IDLE) && (temp_q[i] < WarnTemp);
            all_hot_c   = all_hot_c & (temp_q[i] >= WarnTemp);
            if (eligible[i] && (!sel_found || (temp_q[i] < sel_temp))) begin
                sel_found = 1'b1;
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_temp  = temp_q[i];
            end
        end
    end

    assign accept = job_valid && sel_found;

    always_comb begin
        core_start_d = accept ? sel_oh : '0;
        core_tag_d   = accept ? job_tag : core_tag_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            temp_q       <= '0;
            core_start_q <= '0;
            core_tag_q   <= '0;
        end else begin
            temp_q       <= temp_d;
            core_start_q <= core_start_d;
            core_tag_q   <= core_tag_d;
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
        core_job_slot #(
            .TEMP_W   (TEMP_W),
            .JOB_W    (JOB_W),
            .TAG_W    (TAG_W),
            .T_CRIT   (T_CRIT),
            .T_RESUME (T_RESUME)
        ) u_slot (
            .clk_i       (CLK),
            .rst_i       (RST),
            .start_i     (accept && sel_oh[g]),
            .cycles_i    (job_cycles),
            .tag_i       (job_tag),
            .temp_i      (temp_q[g]),
            .state_o     (slot_state[g]),
            .busy_o      (core_busy[g]),
            .throttled_o (core_throttled[g]),
            .done_o      (done_valid[g]),
            .done_tag_o  (done_tag[g*TAG_W +: TAG_W])
        );
    end

    assign job_ready  = sel_found;
    assign core_start = core_start_q;
    assign core_tag   = core_tag_q;
    assign all_hot    = all_hot_c;

endmodule

// File: tb/tb_thermal_job_scheduler.sv
// Directed bench for thermal_job_scheduler with hand-computed expectations.
module tb_thermal_job_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic        job_valid;
    logic        job_ready;
    logic [15:0] job_cycles;
    logic [3:0]  job_tag;
    logic [20:0] core_temp;
    logic [2:0]  core_start;
    logic [3:0]  core_tag;
    logic [2:0]  core_busy;
    logic [2:0]  core_throttled;
    logic [2:0]  done_valid;
    logic [11:0] done_tag;
    logic        all_hot;

    int checks   = 0;
    int failures = 0;

    thermal_job_scheduler dut (
        .CLK            (CLK),
        .RST            (RST),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_cycles     (job_cycles),
        .job_tag        (job_tag),
        .core_temp      (core_temp),
        .core_start     (core_start),
        .core_tag       (core_tag),
        .core_busy      (core_busy),
        .core_throttled (core_throttled),
        .done_valid     (done_valid),
        .done_tag       (done_tag),
        .all_hot        (all_hot)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic temps(input int t0, input int t1, input int t2);
        core_temp = {7'(t2), 7'(t1), 7'(t0)};
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] done_seen;
        RST        = 1'b1;
        job_valid  = 1'b0;
        job_cycles = '0;
        job_tag    = '0;
        temps(39, 20, 40);
        tick(1);
        chk("rst_start", 32'(core_start), 32'h0);
        chk("rst_busy", 32'(core_busy), 32'h0);
        chk("rst_thr", 32'(core_throttled), 32'h0);
        chk("rst_done", 32'(done_valid), 32'h0);
        chk("rst_dtag", 32'(done_tag), 32'h0);
        chk("rst_ctag", 32'(core_tag), 32'h0);
        chk("rst_ready", 32'(job_ready), 32'h1);
        chk("rst_allhot", 32'(all_hot), 32'h0);
        tick(1);
        RST = 1'b0;

        // Coolest core (1) wins, completion L edges after accept
        tick(1);
        job_valid = 1'b1; job_cycles = 16'd5; job_tag = 4'd3;
        chk("t1_ready", 32'(job_ready), 32'h1);
        tick(1);
        job_valid = 1'b0;
        chk("t1_start", 32'(core_start), 32'h2);
        chk("t1_ctag", 32'(core_tag), 32'h3);
        chk("t1_busy", 32'(core_busy), 32'h2);
        tick(1);
        chk("t1_pulse", 32'(core_start), 32'h0);
        tick(3);
        chk("t1_early", 32'(done_valid), 32'h0);
        tick(1);
        chk("t1_done", 32'(done_valid), 32'h2);
        chk("t1_dtag", 32'(done_tag[7:4]), 32'h3);
        tick(1);
        chk("t1_done_off", 32'(done_valid), 32'h0);
        chk("t1_idle", 32'(core_busy), 32'h0);

        // Equal temps: round fill by index, fourth job stalls
        temps(45, 45, 45);
        tick(1);
        job_valid = 1'b1; job_cycles = 16'd4; job_tag = 4'd1;
        tick(1);
        chk("t2_a", 32'(core_start), 32'h1);
        job_tag = 4'd2;
        tick(1);
        chk("t2_b", 32'(core_start), 32'h2);
        job_tag = 4'd5;
        tick(1);
        chk("t2_c", 32'(core_start), 32'h4);
        job_tag = 4'd7; job_cycles = 16'd2;
        chk("t2_full", 32'(job_ready), 32'h0);
        tick(1);
        chk("t2_hold_rdy", 32'(job_ready), 32'h0);
        chk("t2_hold_st", 32'(core_start), 32'h0);
        tick(1);
        chk("t2_done_a", 32'(done_valid), 32'h1);
        chk("t2_dtag_a", 32'(done_tag[3:0]), 32'h1);
        chk("t2_rdy_again", 32'(job_ready), 32'h1);
        tick(1);
        job_valid = 1'b0;
        chk("t2_d", 32'(core_start), 32'h1);
        chk("t2_d_tag", 32'(core_tag), 32'h7);
        chk("t2_done_b", 32'(done_valid), 32'h2);
        chk("t2_dtag_b", 32'(done_tag[7:4]), 32'h2);
        tick(1);
        chk("t2_done_c", 32'(done_valid), 32'h4);
        chk("t2_dtag_c", 32'(done_tag[11:8]), 32'h5);
        tick(1);
        chk("t2_done_d", 32'(done_valid), 32'h1);
        chk("t2_dtag_d", 32'(done_tag[3:0]), 32'h7);

        // Core 2 throttles mid-job, holds through hysteresis band, then resumes
        temps(50, 50, 30);
        tick(1);
        job_valid = 1'b1; job_cycles = 16'd6; job_tag = 4'd9;
        tick(1);
        job_valid = 1'b0;
        chk("t3_start", 32'(core_start), 32'h4);
        temps(50, 50, 80);
        tick(1);
        chk("t3_thr_1", 32'(core_throttled), 32'h0);
        tick(1);
        chk("t3_thr_2", 32'(core_throttled), 32'h4);
        chk("t3_busy", 32'(core_busy), 32'h4);
        chk("t3_rdy", 32'(job_ready), 32'h1);
        temps(50, 50, 73);
        tick(3);
        chk("t3_band", 32'(core_throttled), 32'h4);
        temps(50, 50, 60);
        tick(1);
        chk("t3_still", 32'(core_throttled), 32'h4);
        tick(1);
        chk("t3_resume", 32'(core_throttled), 32'h0);
        tick(4);
        chk("t3_early", 32'(done_valid), 32'h0);
        tick(1);
        chk("t3_done", 32'(done_valid), 32'h4);
        chk("t3_dtag", 32'(done_tag[11:8]), 32'h9);

        // All hot, then core 0 cools and becomes eligible
        temps(80, 80, 80);
        tick(1);
        chk("t4_allhot", 32'(all_hot), 32'h1);
        chk("t4_rdy", 32'(job_ready), 32'h0);
        tick(1);
        chk("t4_thr", 32'(core_throttled), 32'h7);
        chk("t4_busy", 32'(core_busy), 32'h0);
        temps(30, 80, 80);
        tick(1);
        chk("t4_allhot_off", 32'(all_hot), 32'h0);
        chk("t4_rdy_cool", 32'(job_ready), 32'h0);
        tick(1);
        chk("t4_thr_res", 32'(core_throttled), 32'h6);
        chk("t4_rdy_res", 32'(job_ready), 32'h1);

        // Throttle hits on the completing cycle: done deferred until resume
        job_valid = 1'b1; job_cycles = 16'd3; job_tag = 4'hA;
        tick(1);
        job_valid = 1'b0;
        chk("t5_start", 32'(core_start), 32'h1);
        tick(1);
        temps(76, 80, 80);
        tick(2);
        chk("t5_nodone", 32'(done_valid), 32'h0);
        chk("t5_thr", 32'(core_throttled), 32'h7);
        chk("t5_busy", 32'(core_busy), 32'h1);
        temps(50, 80, 80);
        tick(2);
        chk("t5_res", 32'(core_throttled), 32'h6);
        chk("t5_nodone2", 32'(done_valid), 32'h0);
        tick(1);
        chk("t5_done", 32'(done_valid), 32'h1);
        chk("t5_dtag", 32'(done_tag[3:0]), 32'hA);

        // Reset with two jobs in flight
        temps(40, 40, 40);
        tick(2);
        chk("t6_rdy", 32'(job_ready), 32'h1);
        job_valid = 1'b1; job_cycles = 16'd20; job_tag = 4'd4;
        tick(1);
        chk("t6_a", 32'(core_start), 32'h1);
        job_tag = 4'd6;
        tick(1);
        chk("t6_b", 32'(core_start), 32'h2);
        job_valid = 1'b0;
        tick(2);
        chk("t6_busy_pre", 32'(core_busy), 32'h3);
        #2 RST = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(core_busy), 32'h0);
        chk("t6_rst_ctag", 32'(core_tag), 32'h0);
        chk("t6_rst_dtag", 32'(done_tag), 32'h0);
        chk("t6_rst_rdy", 32'(job_ready), 32'h1);
        tick(1);
        RST = 1'b0;
        done_seen = '0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            done_seen = done_seen | done_valid;
        end
        chk("t6_no_done", 32'(done_seen), 32'h0);

        // Zero-length job runs as one cycle
        job_valid = 1'b1; job_cycles = 16'd0; job_tag = 4'd2;
        tick(1);
        job_valid = 1'b0;
        chk("t7_start", 32'(core_start), 32'h1);
        tick(1);
        chk("t7_done", 32'(done_valid), 32'h1);
        chk("t7_dtag", 32'(done_tag[3:0]), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
